// File: rtl/vscale_hasti_core_arbiter_pkg.sv
`default_nettype none
//--------------------------------------------------------------------------
// vscale_hasti_core_arbiter_pkg: shared HASTI widths/encodings. Rev 1.0
//--------------------------------------------------------------------------
package vscale_hasti_core_arbiter_pkg;

  localparam int DEFAULT_NUM_CORES = 4;

  localparam int HASTI_ADDR_WIDTH  = 32;
  localparam int HASTI_BUS_WIDTH   = 32;
  localparam int HASTI_SIZE_WIDTH  = 3;
  localparam int HASTI_BURST_WIDTH = 3;
  localparam int HASTI_PROT_WIDTH  = 4;
  localparam int HASTI_TRANS_WIDTH = 2;

  typedef enum logic [1:0] {
    HASTI_TRANS_IDLE   = 2'd0,
    HASTI_TRANS_BUSY   = 2'd1,
    HASTI_TRANS_NONSEQ = 2'd2,
    HASTI_TRANS_SEQ    = 2'd3
  } hasti_trans_e;

  localparam logic HASTI_RESP_OKAY  = 1'b0;
  localparam logic HASTI_RESP_ERROR = 1'b1;

  // NONSEQ and SEQ both have bit 1 set; IDLE/BUSY do not.
  function automatic logic is_request(input logic [HASTI_TRANS_WIDTH-1:0] trans);
    return trans[1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/vscale_rr_arbiter.sv
`default_nettype none
//--------------------------------------------------------------------------
// vscale_rr_arbiter: round-robin grant with internal pointer. Rev 1.0
//--------------------------------------------------------------------------
module vscale_rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          grant_valid
);

  logic [PW-1:0] ptr;

  // First requester at or after ptr, wrapping.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!grant_valid && req[(int'(ptr) + k) % N]) begin
        grant_valid = 1'b1;
        grant_idx   = PW'((int'(ptr) + k) % N);
        grant[(int'(ptr) + k) % N] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && grant_valid) begin
      ptr <= PW'((int'(grant_idx) + 1) % N);
    end
  end

endmodule
`default_nettype wire

// File: rtl/vscale_hasti_core_arbiter.sv
`default_nettype none
//--------------------------------------------------------------------------
// vscale_hasti_core_arbiter: shares one HASTI SRAM port among core masters. Rev 1.0
//--------------------------------------------------------------------------
module vscale_hasti_core_arbiter
  import vscale_hasti_core_arbiter_pkg::*;
#(
  parameter int NUM_CORES = DEFAULT_NUM_CORES,
  parameter int PTR_W     = $clog2(NUM_CORES)
) (
  input  logic                         hclk,
  input  logic                         hresetn,
  input  logic [HASTI_ADDR_WIDTH-1:0]  m_haddr     [0:NUM_CORES-1],
  input  logic                         m_hwrite    [0:NUM_CORES-1],
  input  logic [HASTI_SIZE_WIDTH-1:0]  m_hsize     [0:NUM_CORES-1],
  input  logic [HASTI_BURST_WIDTH-1:0] m_hburst    [0:NUM_CORES-1],
  input  logic                         m_hmastlock [0:NUM_CORES-1],
  input  logic [HASTI_PROT_WIDTH-1:0]  m_hprot     [0:NUM_CORES-1],
  input  logic [HASTI_TRANS_WIDTH-1:0] m_htrans    [0:NUM_CORES-1],
  input  logic [HASTI_BUS_WIDTH-1:0]   m_hwdata    [0:NUM_CORES-1],
  output logic [HASTI_BUS_WIDTH-1:0]   m_hrdata    [0:NUM_CORES-1],
  output logic                         m_hready    [0:NUM_CORES-1],
  output logic                         m_hresp     [0:NUM_CORES-1],
  output logic [HASTI_ADDR_WIDTH-1:0]  s_haddr,
  output logic                         s_hwrite,
  output logic [HASTI_SIZE_WIDTH-1:0]  s_hsize,
  output logic [HASTI_BURST_WIDTH-1:0] s_hburst,
  output logic                         s_hmastlock,
  output logic [HASTI_PROT_WIDTH-1:0]  s_hprot,
  output logic [HASTI_TRANS_WIDTH-1:0] s_htrans,
  output logic [HASTI_BUS_WIDTH-1:0]   s_hwdata,
  input  logic [HASTI_BUS_WIDTH-1:0]   s_hrdata,
  input  logic                         s_hready,
  input  logic                         s_hresp
);

  logic [NUM_CORES-1:0] req;
  logic [NUM_CORES-1:0] grant;
  logic [PTR_W-1:0]     win_idx;
  logic                 win_valid;

  logic                 dp_valid;
  logic                 dp_write;
  logic [PTR_W-1:0]     dp_owner;

  logic [NUM_CORES-1:0]       hold_valid;
  logic [HASTI_BUS_WIDTH-1:0] hold_data [0:NUM_CORES-1];

  logic unused_lock;

  // Requests are masked by reset so the slave sees IDLE the moment hresetn drops.
  always_comb begin
    unused_lock = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      req[i]      = hresetn && is_request(m_htrans[i]);
      unused_lock = unused_lock | m_hmastlock[i];
    end
  end

  vscale_rr_arbiter #(
    .N  (NUM_CORES),
    .PW (PTR_W)
  ) u_arb (
    .clk         (hclk),
    .rst_n       (hresetn),
    .req         (req),
    .advance     (s_hready),
    .grant       (grant),
    .grant_idx   (win_idx),
    .grant_valid (win_valid)
  );

  always_comb begin
    s_haddr  = '0;
    s_hwrite = 1'b0;
    s_hsize  = '0;
    s_hburst = '0;
    s_hprot  = '0;
    s_htrans = HASTI_TRANS_IDLE;
    if (win_valid) begin
      s_haddr  = m_haddr[win_idx];
      s_hwrite = m_hwrite[win_idx];
      s_hsize  = m_hsize[win_idx];
      s_hburst = m_hburst[win_idx];
      s_hprot  = m_hprot[win_idx];
      s_htrans = m_htrans[win_idx];
    end
  end

  assign s_hmastlock = 1'b0;
  assign s_hwdata    = dp_valid ? m_hwdata[dp_owner] : '0;

  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      m_hready[i] = !hresetn || (s_hready && (!req[i] || grant[i]));
      m_hrdata[i] = hold_valid[i] ? hold_data[i] : s_hrdata;
      m_hresp[i]  = (dp_valid && (dp_owner == PTR_W'(i))) ? s_hresp : HASTI_RESP_OKAY;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_owner <= '0;
    end else if (s_hready) begin
      dp_valid <= win_valid;
      if (win_valid) begin
        dp_owner <= win_idx;
        dp_write <= m_hwrite[win_idx];
      end
    end
  end

  // A read that completes while its owner is stalled on a new address phase
  // is parked here until that master next sees hready.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      hold_valid <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        hold_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (m_hready[i]) begin
          hold_valid[i] <= 1'b0;
        end else if (dp_valid && !dp_write && s_hready && (dp_owner == PTR_W'(i))) begin
          hold_valid[i] <= 1'b1;
          hold_data[i]  <= s_hrdata;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vscale_hasti_core_arbiter.sv
`default_nettype none
//--------------------------------------------------------------------------
// tb_vscale_hasti_core_arbiter: directed + random checks against a bench model. Rev 1.0
//--------------------------------------------------------------------------
module tb_vscale_hasti_core_arbiter;

  localparam int N = 4;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic [31:0] m_haddr     [0:N-1];
  logic        m_hwrite    [0:N-1];
  logic [2:0]  m_hsize     [0:N-1];
  logic [2:0]  m_hburst    [0:N-1];
  logic        m_hmastlock [0:N-1];
  logic [3:0]  m_hprot     [0:N-1];
  logic [1:0]  m_htrans    [0:N-1];
  logic [31:0] m_hwdata    [0:N-1];
  logic [31:0] m_hrdata    [0:N-1];
  logic        m_hready    [0:N-1];
  logic        m_hresp     [0:N-1];
  logic [31:0] s_haddr;
  logic        s_hwrite;
  logic [2:0]  s_hsize;
  logic [2:0]  s_hburst;
  logic        s_hmastlock;
  logic [3:0]  s_hprot;
  logic [1:0]  s_htrans;
  logic [31:0] s_hwdata;
  logic [31:0] s_hrdata;
  logic        s_hready;
  logic        s_hresp;

  int tests = 0;
  int fails = 0;

  vscale_hasti_core_arbiter #(.NUM_CORES(N)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .m_haddr(m_haddr), .m_hwrite(m_hwrite), .m_hsize(m_hsize), .m_hburst(m_hburst),
    .m_hmastlock(m_hmastlock), .m_hprot(m_hprot), .m_htrans(m_htrans), .m_hwdata(m_hwdata),
    .m_hrdata(m_hrdata), .m_hready(m_hready), .m_hresp(m_hresp),
    .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize), .s_hburst(s_hburst),
    .s_hmastlock(s_hmastlock), .s_hprot(s_hprot), .s_htrans(s_htrans), .s_hwdata(s_hwdata),
    .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- SRAM slave model ----------------
  logic [31:0] mem [0:255];
  logic        sl_dv, sl_dw, n_dv, n_dw, wr_pend;
  logic [31:0] sl_addr, n_addr, wr_a, wr_d;

  assign s_hrdata = (sl_dv && !sl_dw) ? mem[sl_addr[9:2]] : 32'h0;

  always @(negedge hclk) begin
    wr_pend = 1'b0;
    if (hresetn !== 1'b1) begin
      n_dv = 1'b0;
    end else if (s_hready) begin
      n_dv    = s_htrans[1];
      n_dw    = s_hwrite;
      n_addr  = s_haddr;
      wr_pend = sl_dv && sl_dw;
      wr_a    = sl_addr;
      wr_d    = s_hwdata;
    end
  end

  always @(posedge hclk) begin
    #1;
    if (hresetn === 1'b1) begin
      if (wr_pend) mem[wr_a[9:2]] = wr_d;
      sl_dv   = n_dv;
      sl_dw   = n_dw;
      sl_addr = n_addr;
    end
  end

  always @(negedge hresetn) begin
    sl_dv = 1'b0; n_dv = 1'b0; wr_pend = 1'b0;
  end

  // ---------------- behavioural arbiter model ----------------
  int          mptr, nptr, mown, nown;
  bit          mdv, ndv, mdw, ndw;
  bit          mhv [N];
  bit          nhv [N];
  logic [31:0] mhd [N];
  logic [31:0] nhd [N];

  task automatic model_reset();
    mptr = 0; mdv = 0; mdw = 0; mown = 0;
    nptr = 0; ndv = 0; ndw = 0; nown = 0;
    for (int i = 0; i < N; i++) begin
      mhv[i] = 0; mhd[i] = 0; nhv[i] = 0; nhd[i] = 0;
    end
  endtask

  always @(negedge hresetn) model_reset();

  always @(posedge hclk) begin
    if (hresetn !== 1'b1) model_reset();
    else begin
      mptr = nptr; mdv = ndv; mdw = ndw; mown = nown;
      mhv = nhv; mhd = nhd;
    end
  end

  always @(negedge hclk) begin
    int w;
    bit eh [N];
    bit rst_on;
    rst_on = (hresetn !== 1'b1);
    w = -1;
    for (int k = 0; k < N; k++) begin
      if (w < 0 && !rst_on && m_htrans[(mptr + k) % N][1]) w = (mptr + k) % N;
    end
    chk("s_htrans",    32'(s_htrans),    w >= 0 ? 32'(m_htrans[w]) : 32'h0);
    chk("s_haddr",     s_haddr,          w >= 0 ? m_haddr[w]        : 32'h0);
    chk("s_hwrite",    32'(s_hwrite),    w >= 0 ? 32'(m_hwrite[w])  : 32'h0);
    chk("s_hsize",     32'(s_hsize),     w >= 0 ? 32'(m_hsize[w])   : 32'h0);
    chk("s_hburst",    32'(s_hburst),    w >= 0 ? 32'(m_hburst[w])  : 32'h0);
    chk("s_hprot",     32'(s_hprot),     w >= 0 ? 32'(m_hprot[w])   : 32'h0);
    chk("s_hmastlock", 32'(s_hmastlock), 32'h0);
    chk("s_hwdata",    s_hwdata,         mdv ? m_hwdata[mown] : 32'h0);
    for (int i = 0; i < N; i++) begin
      eh[i] = rst_on || (s_hready && (!m_htrans[i][1] || w == i));
      chk($sformatf("m_hready[%0d]", i), 32'(m_hready[i]), 32'(eh[i]));
      chk($sformatf("m_hrdata[%0d]", i), m_hrdata[i], mhv[i] ? mhd[i] : s_hrdata);
      chk($sformatf("m_hresp[%0d]", i), 32'(m_hresp[i]), (mdv && mown == i) ? 32'(s_hresp) : 32'h0);
    end
    nptr = mptr; ndv = mdv; ndw = mdw; nown = mown; nhv = mhv; nhd = mhd;
    if (s_hready) begin
      if (w >= 0) begin
        nptr = (w + 1) % N; ndv = 1; nown = w; ndw = m_hwrite[w];
      end else begin
        ndv = 0;
      end
    end
    for (int i = 0; i < N; i++) if (eh[i]) nhv[i] = 0;
    if (mdv && !mdw && s_hready && !eh[mown]) begin
      nhv[mown] = 1; nhd[mown] = s_hrdata;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge hclk); #1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) begin
      m_htrans[i] = 2'd0; m_haddr[i] = 32'h0; m_hwrite[i] = 1'b0; m_hsize[i] = 3'd2;
      m_hburst[i] = 3'd0; m_hmastlock[i] = 1'b0; m_hprot[i] = 4'h3; m_hwdata[i] = 32'h0;
    end
  endtask

  task automatic set_m(input int i, input logic [1:0] t, input logic [31:0] a, input logic wr);
    m_htrans[i] = t; m_haddr[i] = a; m_hwrite[i] = wr;
  endtask

  task automatic do_reset();
    cyc(); hresetn = 1'b0; idle_all(); s_hready = 1'b1;
    cyc(); hresetn = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h5A000000 | (i * 32'h00010101);
    mem[4]  = 32'hDEADBEEF;
    mem[16] = 32'h11111111;
    mem[17] = 32'h22222222;
    mem[18] = 32'h33333333;
    sl_dv = 1'b0; sl_dw = 1'b0; sl_addr = 32'h0; n_dv = 1'b0; n_dw = 1'b0; n_addr = 32'h0;
    wr_pend = 1'b0; wr_a = 32'h0; wr_d = 32'h0;
    model_reset();
    hresetn = 1'b0; s_hready = 1'b1; s_hresp = 1'b0;
    idle_all();
    cyc(); cyc();
    @(negedge hclk);
    chk("rst_htrans", 32'(s_htrans), 32'h0);
    chk("rst_hready0", 32'(m_hready[0]), 32'h1);
    cyc(); hresetn = 1'b1;

    // single read from m0
    cyc(); set_m(0, 2'd2, 32'h10, 1'b0);
    @(negedge hclk);
    chk("t1_htrans", 32'(s_htrans), 32'h2);
    chk("t1_haddr", s_haddr, 32'h10);
    chk("t1_hready_a", 32'(m_hready[0]), 32'h1);
    cyc(); idle_all();
    @(negedge hclk);
    chk("t1_hrdata", m_hrdata[0], 32'hDEADBEEF);
    chk("t1_hready_d", 32'(m_hready[0]), 32'h1);

    // m0/m1 collide straight after reset
    do_reset();
    cyc(); set_m(0, 2'd2, 32'h0, 1'b0); set_m(1, 2'd2, 32'h4, 1'b0);
    @(negedge hclk);
    chk("t2_hready1_lose", 32'(m_hready[1]), 32'h0);
    chk("t2_hready0_win", 32'(m_hready[0]), 32'h1);
    chk("t2_haddr0", s_haddr, 32'h0);
    cyc(); set_m(0, 2'd0, 32'h0, 1'b0);
    @(negedge hclk);
    chk("t2_hready1_win", 32'(m_hready[1]), 32'h1);
    chk("t2_haddr1", s_haddr, 32'h4);
    cyc(); idle_all();
    @(negedge hclk);
    chk("t2_rr_ptr", 32'(dut.u_arb.ptr), 32'h2);

    // all four request continuously
    do_reset();
    cyc();
    for (int i = 0; i < N; i++) set_m(i, 2'd2, 32'(i * 4), 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge hclk);
      chk($sformatf("t3_order%0d", k), s_haddr, 32'((k % N) * 4));
      cyc();
    end
    idle_all();

    // read hold while m0 stalls behind m1
    do_reset();
    cyc(); set_m(0, 2'd2, 32'h40, 1'b0);
    cyc(); set_m(0, 2'd2, 32'h44, 1'b0); set_m(1, 2'd2, 32'h48, 1'b0);
    @(negedge hclk);
    chk("t4_m0_stall", 32'(m_hready[0]), 32'h0);
    chk("t4_m0_data", m_hrdata[0], 32'h11111111);
    cyc(); set_m(1, 2'd0, 32'h0, 1'b0);
    @(negedge hclk);
    chk("t4_m0_grant", 32'(m_hready[0]), 32'h1);
    chk("t4_m0_held", m_hrdata[0], 32'h11111111);
    chk("t4_m1_data", m_hrdata[1], 32'h33333333);
    cyc(); idle_all();
    @(negedge hclk);
    chk("t4_m0_cleared", m_hrdata[0], 32'h22222222);

    // m2 write then read back
    cyc(); set_m(2, 2'd2, 32'h20, 1'b1);
    cyc(); set_m(2, 2'd0, 32'h0, 1'b0); m_hwdata[2] = 32'hCAFEF00D;
    @(negedge hclk);
    chk("t5_hwdata", s_hwdata, 32'hCAFEF00D);
    cyc(); set_m(2, 2'd2, 32'h20, 1'b0); m_hwdata[2] = 32'h0;
    cyc(); idle_all();
    @(negedge hclk);
    chk("t5_readback", m_hrdata[2], 32'hCAFEF00D);

    // async reset during a stalled data phase
    cyc(); set_m(0, 2'd2, 32'h30, 1'b1); set_m(1, 2'd2, 32'h34, 1'b0);
    cyc(); set_m(0, 2'd0, 32'h0, 1'b0); m_hwdata[0] = 32'h12345678; s_hready = 1'b0;
    #1; hresetn = 1'b0;
    #1;
    chk("t6_htrans_idle", 32'(s_htrans), 32'h0);
    for (int i = 0; i < N; i++) chk($sformatf("t6_hready_rst%0d", i), 32'(m_hready[i]), 32'h1);
    cyc(); hresetn = 1'b1; idle_all(); s_hready = 1'b1;
    @(negedge hclk);
    for (int i = 0; i < N; i++) chk($sformatf("t6_hready_post%0d", i), 32'(m_hready[i]), 32'h1);
    chk("t6_rr_ptr", 32'(dut.u_arb.ptr), 32'h0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      cyc();
      for (int i = 0; i < N; i++) begin
        m_htrans[i] = 2'($urandom_range(0, 3));
        m_haddr[i]  = {22'h0, 8'($urandom), 2'b00};
        m_hwrite[i] = 1'($urandom);
        m_hsize[i]  = 3'($urandom_range(0, 2));
        m_hburst[i] = 3'($urandom);
        m_hprot[i]  = 4'($urandom);
        m_hwdata[i] = $urandom;
      end
      s_hready = ($urandom_range(0, 3) != 0);
      s_hresp  = 1'($urandom);
    end
    cyc(); idle_all(); s_hready = 1'b1;
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vscale_hasti_core_arbiter.md
Name: vscale_hasti_core_arbiter

Overview:
Shares the single per-core HASTI port of the dual-port SRAM among NUM_CORES core data masters. Each cycle it grants the slave address phase to at most one master using round-robin, and tracks the data-phase owner so it can steer hwdata, hrdata and hresp. It stalls losing masters through their hready, and holds completed read data for any master whose data phase is being extended. It sits between the per-core vscale pipelines and the SRAM/memory-side HASTI port.

Parameters:
NUM_CORES, `NUM_CORES (4), number of requesting masters, 2..8.
PTR_W, $clog2(NUM_CORES), width of the grant pointer and owner index.

Ports:
hclk  in  1  clock
hresetn  in  1  reset, asynchronous, active-low
m_haddr[0:NUM_CORES-1]  in  `HASTI_ADDR_WIDTH  master address
m_hwrite[]  in  1  master write
m_hsize[]  in  `HASTI_SIZE_WIDTH  master size
m_hburst[]  in  `HASTI_BURST_WIDTH  master burst
m_hmastlock[]  in  1  master lock (ignored; forwarded 0)
m_hprot[]  in  `HASTI_PROT_WIDTH  master prot
m_htrans[]  in  `HASTI_TRANS_WIDTH  master trans
m_hwdata[]  in  `HASTI_BUS_WIDTH  master write data
m_hrdata[]  out  `HASTI_BUS_WIDTH  read data to master
m_hready[]  out  1  ready to master
m_hresp[]  out  1  response to master
s_haddr, s_hwrite, s_hsize, s_hburst, s_hmastlock, s_hprot, s_htrans, s_hwdata  out  (same widths)  slave-side request
s_hrdata  in  `HASTI_BUS_WIDTH  slave read data
s_hready  in  1  slave ready
s_hresp  in  1  slave response

Behaviour:
- Reset is asynchronous, active-low, on hresetn. Effects: rr_ptr=0, dp_valid=0, dp_owner=0, hold_valid[*]=0, hold_data[*]=0. Outputs while reset is asserted: s_htrans=IDLE, m_hready[*]=1, m_hresp[*]=OKAY.
- A master requests when m_htrans is NONSEQ or SEQ. IDLE and BUSY are treated as no request.
- Grant is combinational. It goes to the first requester at or after rr_ptr, wrapping modulo NUM_CORES.
- When s_hready=1 and a grant exists:
  - rr_ptr <= (winner+1) mod NUM_CORES.
  - dp_valid <= 1, dp_owner <= winner, dp_write <= m_hwrite[winner].
- When s_hready=1 and there is no grant: dp_valid <= 0.
- When s_hready=0: rr_ptr, dp_* and grant state are frozen.
- s_h* address-phase outputs are muxed from the winner.
  - With no winner: s_htrans=IDLE and the other fields are 0.
  - s_hmastlock is always 0.
- s_hwdata = m_hwdata[dp_owner] (0 if !dp_valid).
- m_hready[i] = s_hready AND (!req[i] OR winner==i).
  - A requesting master that loses arbitration sees hready=0 and must hold its address phase.
  - Its data phase is also extended.
- Read hold: if dp_valid, !dp_write, s_hready and m_hready[dp_owner]=0, then hold_valid[owner] <= 1 and hold_data[owner] <= s_hrdata.
  - hold_valid[i] clears on any cycle with m_hready[i]=1.
- m_hrdata[i] = hold_valid[i] ? hold_data[i] : s_hrdata (broadcast).
- m_hresp[i] = s_hresp when dp_valid and dp_owner==i, else OKAY.
- Latency: no added cycles to a granted master. Read data appears in the cycle after the address phase, same as the direct SRAM connection.
- Fairness: with s_hready=1, a persistent requester is granted within NUM_CORES-1 cycles.
- Back-to-back: the same master may win consecutive cycles only when no other master is requesting.
- Reset mid-transfer: in-flight data phase and hold buffers are discarded. No write reaches the slave after reset asserts, because s_htrans is IDLE.

Decomposition:
- HASTI_TRANS_*, HASTI_RESP_* and the width macros come from the shared vscale_hasti_constants.vh.
- Add `NUM_CORES there if it is absent.
- One sub-module: vscale_rr_arbiter. It is parameterised on N, takes the req vector, rr_ptr and an advance enable, and returns a one-hot grant plus the index. It holds the pointer flop internally.

Test Plan:
- Only m0 reads 0x10 (NONSEQ) with the SRAM returning 0xDEADBEEF -> s_htrans=NONSEQ with s_haddr=0x10 that cycle; m_hrdata[0]=0xDEADBEEF next cycle; m_hready[0]=1 throughout.
- m0 and m1 issue NONSEQ in the same cycle after reset -> m0 granted (m_hready[1]=0); next cycle m1 granted; rr_ptr=2.
- All 4 masters request continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3; no master waits more than 3 cycles.
- m0 reads addr A (data 0x11111111), then requests again while m1 wins -> m_hrdata[0] holds 0x11111111 until m0 is granted; the hold clears that cycle.
- m2 writes 0xCAFEF00D to 0x20 with m3 idle -> s_hwdata=0xCAFEF00D in the data cycle; a later read of 0x20 returns 0xCAFEF00D.
- hresetn pulsed low mid data phase with s_hready=0 -> s_htrans=IDLE immediately; after release, all m_hready=1 and rr_ptr=0.
